itof_pipe: RTL



---
 rtl/fpu_pkg.sv | 27 ++
 rtl/lzc32.sv | 27 ++
 rtl/itof_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision layout and small helpers
// used by the conversion units (itof, ftoi) and the rest of the FPU.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  // Exponent of a value whose leading one sits in bit 31 of a 32-bit word.
  localparam int ITOF_EXP_TOP = BIAS + 31;

  typedef struct packed {
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  localparam fp32_t FP32_ZERO = '0;

  // Leading-zero count of one byte, 0..8.
  function automatic logic [3:0] lz8(input logic [7:0] v);
    lz8 = 4'd8;
    for (int i = 0; i < 8; i++)
      if (v[i]) lz8 = 4'(7 - i);
  endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero word.
// Built as four byte counters followed by a priority pick of the top non-zero byte.
module lzc32
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic [5:0]  cnt
);

  logic [3:0] byte_lz [4];
  logic [3:0] byte_nz;

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign byte_lz[b] = lz8(x[8*b +: 8]);
    assign byte_nz[b] = |x[8*b +: 8];
  end

  // Highest non-zero byte decides; lower bytes only matter when all above are zero.
  always_comb begin
    cnt = 6'd32;
    if (byte_nz[3])      cnt = {2'b00, byte_lz[3]};
    else if (byte_nz[2]) cnt = 6'd8  + {2'b00, byte_lz[2]};
    else if (byte_nz[1]) cnt = 6'd16 + {2'b00, byte_lz[1]};
    else if (byte_nz[0]) cnt = 6'd24 + {2'b00, byte_lz[0]};
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer-to-float converter (round to nearest, ties to even).
// S1 sign/magnitude, S2 normalise, S3 round and pack. A single global
// advance enable stalls the whole pipe under output backpressure.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  logic            en;

  // S1 state
  logic             s1_sgn;
  logic [31:0]      s1_mag;
  logic [TAG_W-1:0] s1_tag;

  // S2 state
  logic             s2_sgn;
  logic             s2_zero;
  logic [31:0]      s2_norm;
  logic [5:0]       s2_lz;
  logic [TAG_W-1:0] s2_tag;

  // S3 state (drives the outputs directly)
  fp32_t            s3_res;
  logic [TAG_W-1:0] s3_tag;

  // Combinational stage inputs
  logic             c1_sgn;
  logic [31:0]      c1_mag;
  logic [5:0]       c2_lz;
  logic [31:0]      c2_norm;
  fp32_t            c3_res;

  // Bubbles are kept; everything moves together or nothing moves.
  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign out_y     = s3_res;
  assign out_tag   = s3_tag;

  // Valid shift register; reset flushes every in-flight operand.
  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1 combinational: sign and magnitude. -0x80000000 wraps to 0x80000000,
  // which is the correct unsigned magnitude.
  always_comb begin
    c1_sgn = !in_unsigned && in_x[31];
    c1_mag = c1_sgn ? (~in_x + 32'd1) : in_x;
  end

  // S1 register: data is don't-care when the slot is empty.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sgn <= c1_sgn;
      s1_mag <= c1_mag;
      s1_tag <= in_tag;
    end
  end

  lzc32 u_lzc (
    .x   (s1_mag),
    .cnt (c2_lz)
  );

  // S2 combinational: shift the leading one up to bit 31 (lz=32 only for zero).
  always_comb begin
    c2_norm = (c2_lz[5]) ? 32'd0 : (s1_mag << c2_lz[4:0]);
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (en) begin
      s2_sgn  <= s1_sgn;
      s2_zero <= (s1_mag == 32'd0);
      s2_norm <= c2_norm;
      s2_lz   <= c2_lz;
      s2_tag  <= s1_tag;
    end
  end

  // S3 combinational: round to nearest even and pack. Carry out of the
  // mantissa leaves it zero and bumps the exponent; 2^32 is the maximum,
  // so the exponent can never overflow.
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        rnd_up;
  logic [23:0] mant_r;
  logic [7:0]  exp_b;

  always_comb begin
    mant   = s2_norm[30:8];
    guard  = s2_norm[7];
    sticky = |s2_norm[6:0];
    rnd_up = guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd_up};
    exp_b  = 8'(ITOF_EXP_TOP) - {2'b00, s2_lz};
    if (mant_r[23]) exp_b = exp_b + 8'd1;

    c3_res      = FP32_ZERO;
    if (!s2_zero) begin
      c3_res.sgn  = s2_sgn;
      c3_res.exp  = exp_b;
      c3_res.mant = mant_r[22:0];
    end
  end

  // S3 register: output value and tag are cleared by reset and held on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_res <= FP32_ZERO;
      s3_tag <= '0;
    end else if (en) begin
      s3_res <= c3_res;
      s3_tag <= s2_tag;
    end
  end

endmodule
